// File: rtl/fifo_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_pkg
//  Purpose  : Shared types and helpers for the COREFIFO write-side packer:
//             ACC/HOLD state encoding, write-word width and PAD replication.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_wr_pkg;

    // ACC: no completed word waiting; HOLD: out_word is waiting for the FIFO.
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } wr_state_e;

    // Widest packed word the PAD helper can build.
    localparam int c_MAX_W = 1024;

    // Packed FIFO word width for a given sample width and packing factor.
    function automatic int write_width(input int in_width, input int pack);
        return in_width * pack;
    endfunction

    // Replicate one PAD sample into every lane; pad must be zero above in_width.
    function automatic logic [c_MAX_W-1:0] pad_fill(input logic [c_MAX_W-1:0] pad,
                                                    input int               in_width,
                                                    input int               pack);
        logic [c_MAX_W-1:0] r;
        r = '0;
        for (int j = 0; j < pack; j++) begin
            r = r | (pad << (j * in_width));
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_stats.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_stats
//  Purpose  : Write/drop statistics for the FIFO packer. wr_count wraps,
//             drop_count saturates, overflow is sticky; a clear beats any
//             increment on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_stats #(
    parameter int CNT_W = 16
) (
    input  logic             fifo_wclk,
    input  logic             fifo_reset,
    input  logic             clr_i,
    input  logic             inc_wr_i,
    input  logic             inc_drop_i,
    output logic [CNT_W-1:0] wr_count_o,
    output logic [CNT_W-1:0] drop_count_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] wr_q,   wr_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q,  ovf_d;

    // Next-state: clear has priority, then wrap/saturate increments.
    always_comb begin
        wr_d   = wr_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (clr_i) begin
            wr_d   = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (inc_wr_i) begin
                wr_d = wr_q + 1'b1;
            end
            if (inc_drop_i) begin
                ovf_d = 1'b1;
                if (drop_q != c_CNT_MAX) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    // Counter registers with asynchronous active-low reset.
    always_ff @(posedge fifo_wclk or negedge fifo_reset) begin
        if (!fifo_reset) begin
            wr_q   <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign wr_count_o   = wr_q;
    assign drop_count_o = drop_q;
    assign overflow_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_packer
//  Purpose  : Packs PACK narrow samples into one FIFO write word, drives the
//             COREFIFO we/wdata pair against the full flag, and either
//             backpressures upstream or drops whole words when full.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_packer
    import fifo_wr_pkg::*;
#(
    parameter int                  IN_WIDTH     = 9,
    parameter int                  PACK         = 2,
    parameter int                  WE_POLARITY  = 1,
    parameter int                  DROP_ON_FULL = 0,
    parameter logic [IN_WIDTH-1:0] PAD          = '0,
    parameter int                  CNT_W        = 16
) (
    input  logic                     fifo_wclk,
    input  logic                     fifo_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     in_last,
    input  logic                     full,
    output logic                     we,
    output logic [IN_WIDTH*PACK-1:0] wdata,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         wr_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);

    localparam int                   c_WW        = write_width(IN_WIDTH, PACK);
    localparam int                   c_LANE_W    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [c_LANE_W-1:0]  c_LAST_LANE = c_LANE_W'(PACK - 1);
    localparam logic                 c_DROP      = (DROP_ON_FULL != 0);
    localparam logic                 c_WE_LOW    = (WE_POLARITY != 0);
    localparam logic [c_MAX_W-1:0]   c_PAD_ALL   =
        pad_fill({{(c_MAX_W-IN_WIDTH){1'b0}}, PAD}, IN_WIDTH, PACK);
    localparam logic [c_WW-1:0]      c_PAD_WORD  = c_PAD_ALL[c_WW-1:0];

    wr_state_e           state_q, state_d;
    logic [c_LANE_W-1:0] lane_q, lane_d;
    logic [c_WW-1:0]     acc_q, acc_d;
    logic [c_WW-1:0]     out_word_q, out_word_d;

    logic                w_pending;
    logic                w_accept;
    logic                w_complete;
    logic                w_xfer;
    logic                w_drop;
    logic                w_load;
    logic                w_we_active;
    logic [c_WW-1:0]     w_merged;

    assign w_pending   = (state_q == ST_HOLD);
    assign w_xfer      = w_pending & ~full;
    assign in_ready    = c_DROP ? 1'b1 : (~w_pending | ~full);
    assign w_accept    = in_valid & in_ready;
    assign w_complete  = w_accept & ((lane_q == c_LAST_LANE) | in_last);
    // A completing word is discarded only when the held word cannot leave.
    assign w_drop      = c_DROP & w_complete & w_pending & full;
    assign w_load      = w_complete & ~w_drop;
    assign w_we_active = w_xfer;
    assign we          = c_WE_LOW ? ~w_we_active : w_we_active;
    assign wdata       = out_word_q;

    // Accumulator with the incoming sample merged at lane_q; lanes above are PAD.
    always_comb begin
        w_merged = acc_q;
        for (int j = 0; j < PACK; j++) begin
            if (c_LANE_W'(j) == lane_q) begin
                w_merged[j*IN_WIDTH +: IN_WIDTH] = in_data;
            end else if (c_LANE_W'(j) > lane_q) begin
                w_merged[j*IN_WIDTH +: IN_WIDTH] = PAD;
            end
        end
    end

    // Next-state for lane counter, accumulator, output word and ACC/HOLD FSM.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_d      = acc_q;
        out_word_d = out_word_q;

        if (w_accept) begin
            if (w_complete) begin
                lane_d = '0;
                acc_d  = c_PAD_WORD;
            end else begin
                lane_d = lane_q + 1'b1;
                acc_d  = w_merged;
            end
        end

        // Reload on completion, even when the previous word leaves on this edge.
        if (w_load) begin
            out_word_d = w_merged;
        end

        case (state_q)
            ST_ACC: begin
                if (w_load) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_xfer && !w_load) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State registers; reset discards any partial or pending word.
    always_ff @(posedge fifo_wclk or negedge fifo_reset) begin
        if (!fifo_reset) begin
            state_q    <= ST_ACC;
            lane_q     <= '0;
            acc_q      <= c_PAD_WORD;
            out_word_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            out_word_q <= out_word_d;
        end
    end

    fifo_wr_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .fifo_wclk    (fifo_wclk),
        .fifo_reset   (fifo_reset),
        .clr_i        (clr_stats),
        .inc_wr_i     (w_xfer),
        .inc_drop_i   (w_drop),
        .wr_count_o   (wr_count),
        .drop_count_o (drop_count),
        .overflow_o   (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_packer
//  Purpose  : Scoreboard bench for fifo_wr_packer. Two instances share one
//             stimulus stream: #0 backpressures (we active-low, PAD=0),
//             #1 drops on full (we active-high, PAD=0x155).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_packer;

    localparam int             IW   = 9;
    localparam int             PK   = 2;
    localparam int             WW   = IW * PK;
    localparam int             CW   = 16;
    localparam logic [IW-1:0]  PAD1 = 9'h155;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic          full     = 1'b0;
    logic          clr      = 1'b0;
    logic [IW-1:0] in_data  = '0;

    logic          rdy0, we0, ov0, rdy1, we1, ov1;
    logic [WW-1:0] wd0, wd1;
    logic [CW-1:0] wc0, dc0, wc1, dc1;

    always #5 clk = ~clk;

    fifo_wr_packer #(
        .IN_WIDTH(IW), .PACK(PK), .WE_POLARITY(1), .DROP_ON_FULL(0), .PAD(9'h000), .CNT_W(CW)
    ) u_dut0 (
        .fifo_wclk(clk), .fifo_reset(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .full(full), .we(we0), .wdata(wd0),
        .clr_stats(clr), .wr_count(wc0), .drop_count(dc0), .overflow(ov0)
    );

    fifo_wr_packer #(
        .IN_WIDTH(IW), .PACK(PK), .WE_POLARITY(0), .DROP_ON_FULL(1), .PAD(PAD1), .CNT_W(CW)
    ) u_dut1 (
        .fifo_wclk(clk), .fifo_reset(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .full(full), .we(we1), .wdata(wd1),
        .clr_stats(clr), .wr_count(wc1), .drop_count(dc1), .overflow(ov1)
    );

    int n_chk = 0;
    int n_err = 0;
    int low0  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // held: a completed word is waiting for the FIFO; cur_*: samples of the open word.
    int            held  [2];
    int            cur_n [2];
    logic [WW-1:0] cur_w [2];
    logic [CW-1:0] m_wr  [2];
    logic [CW-1:0] m_drop[2];
    logic          m_ovf [2];
    logic [WW-1:0] exp_q [2][$];

    function automatic logic [IW-1:0] pad_of(input int id);
        return (id == 0) ? 9'h000 : PAD1;
    endfunction

    function automatic logic m_ready(input int id);
        return (id == 1) || (held[id] == 0) || !full;
    endfunction

    function automatic logic we_act(input int id);
        return (id == 0) ? ~we0 : we1;
    endfunction

    function automatic logic rdy_of(input int id);
        return (id == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [WW-1:0] wd_of(input int id);
        return (id == 0) ? wd0 : wd1;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            held[id]   = 0;
            cur_n[id]  = 0;
            cur_w[id]  = '0;
            m_wr[id]   = '0;
            m_drop[id] = '0;
            m_ovf[id]  = 1'b0;
            exp_q[id].delete();
        end
    endtask

    task automatic model_step(input int id);
        logic          pend, rdy, xfer, dropped;
        logic [WW-1:0] word;
        pend    = (held[id] != 0);
        rdy     = m_ready(id);
        xfer    = pend && !full;
        dropped = 1'b0;
        if (xfer) held[id] = 0;
        if (in_valid && rdy) begin
            cur_w[id][cur_n[id]*IW +: IW] = in_data;
            cur_n[id]++;
            if (cur_n[id] == PK || in_last) begin
                word = cur_w[id];
                for (int j = cur_n[id]; j < PK; j++) word[j*IW +: IW] = pad_of(id);
                if (pend && full) begin
                    dropped = 1'b1;
                end else begin
                    held[id] = 1;
                    exp_q[id].push_back(word);
                end
                cur_n[id] = 0;
                cur_w[id] = '0;
            end
        end
        if (clr) begin
            m_wr[id]   = '0;
            m_drop[id] = '0;
            m_ovf[id]  = 1'b0;
        end else begin
            if (xfer) m_wr[id] = m_wr[id] + 1'b1;
            if (dropped) begin
                m_ovf[id] = 1'b1;
                if (m_drop[id] != {CW{1'b1}}) m_drop[id] = m_drop[id] + 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (!we0) low0++;
            for (int id = 0; id < 2; id++) begin
                chk($sformatf("in_ready[%0d]", id), 32'(rdy_of(id)), 32'(m_ready(id)));
                chk($sformatf("we_active[%0d]", id), 32'(we_act(id)),
                    32'((held[id] != 0) && !full));
                if (we_act(id)) begin
                    if (exp_q[id].size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL stale_write[%0d]: actual wdata=0x%0h required no write",
                                 id, wd_of(id));
                    end else begin
                        chk($sformatf("wdata[%0d]", id), 32'(wd_of(id)),
                            32'(exp_q[id].pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc      = 1'b0;
        guard    = 0;
        while (!acc) begin
            @(negedge clk);
            acc = rdy0;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                n_chk++;
                n_err++;
                $display("FAIL send_timeout: actual stalled %0d cycles required <=200", guard);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream(input int n, input int base);
        for (int i = 0; i < n; i++) send(IW'(base + i), 1'b0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_wr0"},   32'(wc0), 32'(m_wr[0]));
        chk({tag, "_wr1"},   32'(wc1), 32'(m_wr[1]));
        chk({tag, "_drop0"}, 32'(dc0), 32'(m_drop[0]));
        chk({tag, "_drop1"}, 32'(dc1), 32'(m_drop[1]));
        chk({tag, "_ovf0"},  32'(ov0), 32'(m_ovf[0]));
        chk({tag, "_ovf1"},  32'(ov1), 32'(m_ovf[1]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  l;
        logic done;

        // Reset values, during and after reset.
        idle(3);
        chk("rst_we0", 32'(we0), 32'h1);
        chk("rst_we1", 32'(we1), 32'h0);
        chk("rst_wdata0", 32'(wd0), 32'h0);
        chk("rst_wdata1", 32'(wd1), 32'h0);
        chk("rst_ready0", 32'(rdy0), 32'h1);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_ready1", 32'(rdy1), 32'h1);
        chk("post_rst_we0", 32'(we0), 32'h1);
        check_stats("post_rst");

        // Test 1: two samples -> one write pulse of 0x00401.
        l = low0;
        send(9'h001, 1'b0);
        send(9'h002, 1'b0);
        chk("t1_we_now", 32'(we0), 32'h0);
        chk("t1_wdata", 32'(wd0), 32'h00401);
        idle(5);
        chk("t1_we_low_cycles", 32'(low0 - l), 32'd1);
        chk("t1_wr_count", 32'(wc0), 32'd1);

        // Test 2: 1024 back-to-back samples -> 512 words.
        stream(1024, 0);
        idle(4);
        chk("t2_wr_count", 32'(wc0), 32'd513);
        chk("t2_drop_count", 32'(dc0), 32'd0);
        check_stats("t2");

        // Test 5: early in_last on lane 0.
        send(9'h1AB, 1'b1);
        chk("t5_wdata0", 32'(wd0), 32'h001AB);
        chk("t5_wdata1", 32'(wd1), 32'({PAD1, 9'h1AB}));
        send(9'h011, 1'b0);
        send(9'h022, 1'b0);
        chk("t5_next_word", 32'(wd0), 32'h04411);
        idle(4);

        // Test 3: full for 20 cycles during a stream, plus a clear mid-stream.
        fork
            stream(200, 100);
            begin
                idle(10);
                full = 1'b1;
                idle(20);
                full = 1'b0;
                idle(30);
                clr = 1'b1;
                idle(1);
                clr = 1'b0;
            end
        join
        idle(4);
        check_stats("t3");

        // Test 4: full for 8 cycles; drop-mode instance loses whole words.
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        fork
            stream(60, 300);
            begin
                idle(12);
                full = 1'b1;
                idle(8);
                full = 1'b0;
            end
        join
        idle(4);
        check_stats("t4");
        chk("t4_drop_range", 32'((dc1 == 16'd3) || (dc1 == 16'd4)), 32'h1);
        chk("t4_overflow", 32'(ov1), 32'h1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
        chk("t4_clr_drop", 32'(dc1), 32'h0);
        chk("t4_clr_ovf", 32'(ov1), 32'h0);
        chk("t4_clr_wr", 32'(wc0), 32'h0);

        // Randomized phase: data, in_last, gaps, full and clears.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(IW'($urandom), ($urandom_range(0, 5) == 0));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    full = ($urandom_range(0, 3) == 0);
                    clr  = ($urandom_range(0, 40) == 0);
                end
                full = 1'b0;
                clr  = 1'b0;
            end
        join
        send(9'h0F0, 1'b1);
        idle(5);
        check_stats("rand");

        // Test 6: reset while a word is held against full.
        full = 1'b1;
        send(9'h0AA, 1'b0);
        send(9'h0BB, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_we0_async", 32'(we0), 32'h1);
        chk("t6_we1_async", 32'(we1), 32'h0);
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("t6_ready0", 32'(rdy0), 32'h1);
        chk("t6_ready1", 32'(rdy1), 32'h1);
        full = 1'b0;
        idle(6);
        chk("t6_wr0", 32'(wc0), 32'h0);
        chk("t6_wr1", 32'(wc1), 32'h0);
        chk("t6_we0_idle", 32'(we0), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
